// File: rtl/icache_direct.sv
// rtl/icache_direct.sv - direct-mapped read-only instruction cache with hit/miss statistics
//
// Purpose:
//   Serves instruction fetches from a direct-mapped array of one-word frames.
//   A miss latches the word address and issues a single-word memory read,
//   holding it until memory drops iwait, then refills the frame and returns
//   to lookup. Hit and miss counters saturate at all-ones.
//
// Ports:
//   CLK         system clock, rising edge
//   RST         asynchronous active-high reset
//   imemREN     fetch request from the datapath
//   imemaddr    fetch byte address (bits [1:0] ignored)
//   ihit        fetch data valid this cycle
//   imemload    fetched instruction, 0 when ihit is low
//   iREN        memory read request (high for the whole fill)
//   iaddr       memory word address, 0 outside a fill
//   iload       memory read data, taken when iREN=1 and iwait=0
//   iwait       memory busy
//   hit_count   saturating count of hit cycles
//   miss_count  saturating count of misses
module icache_direct #(
  parameter int SETS  = 16,
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             imemREN,
  input  logic [31:0]      imemaddr,
  output logic             ihit,
  output logic [31:0]      imemload,
  output logic             iREN,
  output logic [31:0]      iaddr,
  input  logic [31:0]      iload,
  input  logic             iwait,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - IDX_W;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic {
    COMPARE = 1'b0,
    FILL    = 1'b1
  } state_t;

  state_t            state;
  logic [SETS-1:0]   valid;
  logic [TAG_W-1:0]  tag_mem  [SETS];
  logic [31:0]       data_mem [SETS];
  logic [29:0]       miss_word;

  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  fill_idx;
  logic [TAG_W-1:0]  fill_tag;
  logic              hit;
  logic              miss;
  logic              fill_done;
  logic              unused_offset;

  assign req_idx   = imemaddr[IDX_W+1:2];
  assign req_tag   = imemaddr[31:IDX_W+2];
  assign fill_idx  = miss_word[IDX_W-1:0];
  assign fill_tag  = miss_word[29:IDX_W];
  // The byte offset never selects anything in a word-wide cache.
  assign unused_offset = ^imemaddr[1:0];

  // Lookup is purely combinational so a hit returns data in the request cycle.
  assign hit       = (state == COMPARE) && imemREN && valid[req_idx] &&
                     (tag_mem[req_idx] == req_tag);
  assign miss      = (state == COMPARE) && imemREN && !hit;
  assign fill_done = (state == FILL) && !iwait;

  assign ihit      = hit;
  assign imemload  = hit ? data_mem[req_idx] : 32'h0;
  // Memory-side outputs depend only on registered state, so they stay stable
  // for the whole fill regardless of what the datapath does.
  assign iREN      = (state == FILL);
  assign iaddr     = (state == FILL) ? {miss_word, 2'b00} : 32'h0;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= COMPARE;
      valid      <= '0;
      miss_word  <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      case (state)
        COMPARE: begin
          if (hit && (hit_count != CNT_MAX)) begin
            hit_count <= hit_count + CNT_ONE;
          end
          if (miss) begin
            miss_word <= imemaddr[31:2];
            state     <= FILL;
            if (miss_count != CNT_MAX) begin
              miss_count <= miss_count + CNT_ONE;
            end
          end
        end
        FILL: begin
          // The fill finishes for the latched address even if the request
          // was redirected or dropped meanwhile.
          if (!iwait) begin
            valid[fill_idx] <= 1'b1;
            state           <= COMPARE;
          end
        end
        default: state <= COMPARE;
      endcase
    end
  end

  // Tag and data need no reset; valid gates them. A reset during a fill
  // forces state to COMPARE immediately, so no write can follow it.
  always_ff @(posedge CLK) begin
    if (fill_done) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= iload;
    end
  end

endmodule
